// File: rtl/dkong3_obj_pkg.sv
// ============================================================================
// dkong3_obj_pkg : shared constants and state type for the object DMA receiver
// Optional build macro: DKONG3_OBJ_DBLBUF_EN (two RAM banks)
// Revision: 1.0
// ============================================================================
`default_nettype none

package dkong3_obj_pkg;

    localparam int RAM_DEPTH = 1024;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);
    localparam int DATA_W    = 8;
    localparam int CNT_W     = 9;

    localparam logic [CNT_W-1:0] DMA_LEN = 9'h19F;

    localparam int TIMEOUT = 16;
    localparam int TMO_W   = $clog2(TIMEOUT);

`ifdef DKONG3_OBJ_DBLBUF_EN
    localparam int BANKS = 2;
`else
    localparam int BANKS = 1;
`endif

    // Physical RAM address: bank bit (when present) above the object address
    localparam int MEM_AW = RAM_AW + $clog2(BANKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } obj_state_e;

    function automatic logic [RAM_AW-1:0] next_addr(input logic [RAM_AW-1:0] a);
        return a + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dkong3_obj_dpram.sv
// ============================================================================
// dkong3_obj_dpram : one write port, one registered read port object RAM
// Revision: 1.0
// ============================================================================
`default_nettype none

module dkong3_obj_dpram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    // Contents are deliberately not reset so data survives a reset pulse
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a same-cycle write to raddr returns the old word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dkong3_obj_dma_rx.sv
// ============================================================================
// dkong3_obj_dma_rx : object-RAM DMA receiver with transfer checking and
// scanner read port. Optional build macro: DKONG3_OBJ_DBLBUF_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module dkong3_obj_dma_rx
    import dkong3_obj_pkg::*;
(
    input  logic                I_CLK,
    input  logic                I_RSTn,
    input  logic [RAM_AW-1:0]   I_DMA_AD,
    input  logic [DATA_W-1:0]   I_DMA_DD,
    input  logic                I_DMA_CED,
    input  logic                I_DMA_WE,
    input  logic                I_VBLK_n,
    input  logic [RAM_AW-1:0]   I_SCAN_A,
    input  logic                I_SCAN_RD,
    output logic [DATA_W-1:0]   O_SCAN_D,
    output logic                O_SCAN_VLD,
    output logic                O_BUSY,
    output logic                O_DONE,
    output logic                O_ERR,
    output logic [CNT_W-1:0]    O_CNT
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    obj_state_e        state;
    obj_state_e        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [RAM_AW-1:0] exp_addr;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              err;
    logic              scan_vld;

    logic              dma_wr;
    logic              start;
    logic              accept;
    logic              order_err;
    logic              idle_err;
    logic              timeout;

    logic [MEM_AW-1:0] wr_addr;
    logic [MEM_AW-1:0] rd_addr;

    assign dma_wr  = I_DMA_CED & I_DMA_WE;
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        accept    = 1'b0;
        order_err = 1'b0;
        idle_err  = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dma_wr) begin
                    if (I_DMA_AD == '0) begin
                        start     = 1'b1;
                        state_nxt = ST_RECV;
                    end else begin
                        idle_err  = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (dma_wr) begin
                    // Address 0 here is just another out-of-order write
                    accept    = 1'b1;
                    order_err = (I_DMA_AD != exp_addr);
                    if (cnt_inc == DMA_LEN) begin
                        state_nxt = ST_DONE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            cnt      <= '0;
            exp_addr <= '0;
            tmo_cnt  <= '0;
        end else if (start) begin
            cnt      <= CNT_W'(1);
            exp_addr <= RAM_AW'(1);
            tmo_cnt  <= '0;
        end else if (accept) begin
            cnt      <= cnt_inc;
            exp_addr <= next_addr(I_DMA_AD);
            tmo_cnt  <= '0;
        end else if (timeout) begin
            tmo_cnt  <= '0;
        end else if (state == ST_RECV) begin
            tmo_cnt  <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            err      <= 1'b0;
            scan_vld <= 1'b0;
        end else begin
            if (idle_err || order_err || timeout) begin
                err <= 1'b1;
            end
            scan_vld <= I_SCAN_RD;
        end
    end

`ifdef DKONG3_OBJ_DBLBUF_EN
    logic bank_sel;
    logic swap_pend;
    logic vblk_q;
    logic vblk_fall;

    assign vblk_fall = vblk_q & ~I_VBLK_n;

    // bank_sel names the front (scanner) bank; DMA always fills the other one
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            bank_sel  <= 1'b0;
            swap_pend <= 1'b0;
            vblk_q    <= 1'b1;
        end else begin
            vblk_q <= I_VBLK_n;
            if (vblk_fall && swap_pend) begin
                bank_sel <= ~bank_sel;
            end
            if (state == ST_DONE) begin
                swap_pend <= 1'b1;
            end else if (vblk_fall) begin
                swap_pend <= 1'b0;
            end
        end
    end

    assign wr_addr = {~bank_sel, I_DMA_AD};
    assign rd_addr = {bank_sel, I_SCAN_A};
`else
    logic unused_vblk;

    assign unused_vblk = I_VBLK_n;
    assign wr_addr     = I_DMA_AD;
    assign rd_addr     = I_SCAN_A;
`endif

    dkong3_obj_dpram #(
        .AW (MEM_AW),
        .DW (DATA_W)
    ) u_ram (
        .clk   (I_CLK),
        .rst_n (I_RSTn),
        .we    (dma_wr),
        .waddr (wr_addr),
        .wdata (I_DMA_DD),
        .re    (I_SCAN_RD),
        .raddr (rd_addr),
        .rdata (O_SCAN_D)
    );

    assign O_SCAN_VLD = scan_vld;
    assign O_BUSY     = (state == ST_RECV);
    assign O_DONE     = (state == ST_DONE);
    assign O_ERR      = err;
    assign O_CNT      = cnt;

endmodule

`default_nettype wire

// File: doc/dkong3_obj_dma_rx.md
DKONG3_OBJ_DMA_RX -- requirements
Module: dkong3_obj_dma_rx

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be:
- I_CLK  in  1  block clock, DMA-side clock domain; all logic on rising edge
- I_RSTn  in  1  asynchronous active-low reset
- I_DMA_AD  in  10  DMA destination address
- I_DMA_DD  in  8  DMA write data
- I_DMA_CED  in  1  DMA destination chip enable
- I_DMA_WE  in  1  DMA write enable; a write occurs only when CED=1 and WE=1
- I_VBLK_n  in  1  vertical blank, active low
- I_SCAN_A  in  10  sprite scanner read address
- I_SCAN_RD  in  1  sprite scanner read strobe
- O_SCAN_D  out  8  scanner read data
- O_SCAN_VLD  out  1  O_SCAN_D valid
- O_BUSY  out  1  transfer in progress
- O_DONE  out  1  one-cycle transfer-complete pulse
- O_ERR  out  1  sticky protocol error
- O_CNT  out  9  bytes received in the current or last transfer

Function
REQ-003 SHALL hold a 1024x8 object RAM per bank; every DMA write (CED&WE) SHALL store I_DMA_DD at I_DMA_AD in the write bank, whatever the state.
REQ-004 SHALL implement states IDLE, RECV and DONE.
REQ-005 IDLE: a write to address 0 SHALL go to RECV and set O_CNT=1 and the expected address to 1.
REQ-006 IDLE: a write to a non-zero address SHALL set O_ERR and stay in IDLE.
REQ-007 RECV: each write SHALL increment O_CNT by one.
REQ-008 RECV: a write whose address differs from the expected address SHALL set O_ERR, and the expected address SHALL resync to that address+1.
REQ-009 RECV: cycles with no write SHALL be allowed; 16 consecutive no-write cycles SHALL set O_ERR and go to IDLE with no O_DONE.
REQ-010 When O_CNT reaches 9'h19F, the block SHALL move to DONE on the next edge. DONE SHALL assert O_DONE for exactly one cycle, then return to IDLE.
REQ-011 O_BUSY SHALL be 1 exactly in RECV.
REQ-012 O_CNT SHALL hold its value in IDLE until the next transfer starts.
REQ-013 Scanner reads SHALL come from the display bank with 1-cycle latency: O_SCAN_VLD=1 and O_SCAN_D valid on the cycle after I_SCAN_RD=1. O_SCAN_VLD SHALL be 0 otherwise, and O_SCAN_D SHALL hold its last value.
REQ-014 A scanner read and a DMA write to the same location in the same cycle SHALL return the old data.
REQ-015 A write to address 0 while in RECV SHALL count as out-of-order (REQ-008); it SHALL NOT restart the transfer.

Reset
REQ-016 Reset SHALL force: state IDLE, O_CNT=0, expected address 0, timeout counter 0, O_BUSY=0, O_DONE=0, O_ERR=0, O_SCAN_VLD=0, O_SCAN_D=0, bank select 0.
REQ-017 Reset SHALL NOT clear RAM contents. Reset during RECV SHALL abort the transfer with no O_DONE.
REQ-018 O_ERR SHALL clear only on reset.

Configuration
REQ-019 Macro DKONG3_OBJ_DBLBUF_EN:
- Defined: two banks. DMA writes the back bank and the scanner reads the front bank. A completed transfer SHALL set a swap-pending flag. Banks SHALL swap on the first falling edge of I_VBLK_n while the flag is set, and the flag SHALL then clear. A second O_DONE before the swap SHALL leave a single pending swap.
- Undefined: one bank shared by DMA and scanner. I_VBLK_n SHALL be unused and there SHALL be no swap logic.

Structure
REQ-020 Package dkong3_obj_pkg SHALL hold DMA_LEN (9'h19F), TIMEOUT (16), the state enum and the RAM depth constant.
REQ-021 RAM SHALL be sub-module dkong3_obj_dpram: one write port and one registered read port, with a bank bit as address MSB when DKONG3_OBJ_DBLBUF_EN is defined.

Verification
REQ-022 Bench SHALL cover:
- 415 consecutive writes, addresses 0..0x19E, data=addr[7:0] -> O_BUSY for the transfer; O_DONE one cycle after the write to 0x19E; O_CNT=0x19F; O_ERR=0; scanner read of addr 0x10 returns 0x10.
- Write to 0x005 in IDLE -> O_ERR=1, state IDLE, O_CNT unchanged.
- Transfer with a 16-cycle gap after 100 writes -> O_ERR=1, IDLE, no O_DONE, O_CNT=100.
- Address skip 0x020 -> 0x022 -> O_ERR=1; transfer continues and completes on O_CNT=0x19F.
- Reset asserted mid-RECV -> all outputs at reset values; RAM data written before reset is still readable.
- DBLBUF_EN: complete a transfer of 0xAA while the front bank holds 0x55 -> scanner reads 0x55 until the I_VBLK_n falling edge, then 0xAA.
